// File: rtl/pe_pkg.sv
// Shared sizing and types for the pe_mac processing element.
// Build option: PE_SATURATE_EN selects clamping instead of wrap-around on pe_out.
package pe_pkg;

  localparam int DATA_W = 8;
  localparam int TAPS   = 9;
  localparam int ACC_W  = 20;
  localparam int CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PE_MAX = (1 << DATA_W) - 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage : pe_pkg

// File: rtl/pe_mul.sv
// Combinational unsigned multiplier; the product is zero-extended to accumulator width.
module pe_mul
  import pe_pkg::*;
#(
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int ACC_W  = pe_pkg::ACC_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  p
);

  logic [2*DATA_W-1:0] full;

  assign full = a * b;
  assign p    = {{(ACC_W-2*DATA_W){1'b0}}, full};

endmodule : pe_mul

// File: rtl/pe_mac.sv
// One-lane MAC for a 3x3 convolution: accumulates TAPS pixel*weight products and
// publishes the window result with a one-cycle done pulse. Build option: PE_SATURATE_EN.
module pe_mac
  import pe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  mode_i,
  input  data_t pe_in,
  input  data_t pe_filter,
  output data_t pe_out,
  output logic  single_count_9
);

`ifdef PE_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam acc_t MAX_ACC  = acc_t'(PE_MAX);
  localparam cnt_t LAST_CNT = cnt_t'(TAPS - 1);

  function automatic data_t sat_fn(input acc_t x);
    if (SAT_EN && (x > MAX_ACC)) return data_t'(PE_MAX);
    return x[DATA_W-1:0];
  endfunction

  acc_t  prod_p0;
  acc_t  sum_p0;
  logic  last_p0;

  acc_t  acc_p1;
  cnt_t  cnt_p1;
  data_t out_p1;
  logic  vld_p1;

  // stage 0: product and running sum from current operands
  pe_mul #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mul (
    .a (pe_in),
    .b (pe_filter),
    .p (prod_p0)
  );

  assign sum_p0  = acc_p1 + prod_p0;
  assign last_p0 = (cnt_p1 == LAST_CNT);

  // stage 1: accumulator, tap counter and published result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p1 <= '0;
      cnt_p1 <= '0;
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (mode_i) begin
        if (last_p0) begin
          acc_p1 <= '0;
          cnt_p1 <= '0;
          out_p1 <= sat_fn(sum_p0);
          vld_p1 <= 1'b1;
        end else begin
          acc_p1 <= sum_p0;
          cnt_p1 <= cnt_p1 + cnt_t'(1);
        end
      end
    end
  end

  assign pe_out         = out_p1;
  assign single_count_9 = vld_p1;

endmodule : pe_mac

// File: tb/tb_pe_mac.sv
// Bench for pe_mac: table-driven windows, hand-written corner sequences, random run vs a window model.
module tb_pe_mac;

  localparam int TAPS = 9;

  logic       clk;
  logic       rst;
  logic       mode_i;
  logic [7:0] pe_in;
  logic [7:0] pe_filter;
  logic [7:0] pe_out;
  logic       single_count_9;

  int checks = 0;
  int errors = 0;

  int win[$];
  int m_out;

  pe_mac dut (
    .clk            (clk),
    .rst            (rst),
    .mode_i         (mode_i),
    .pe_in          (pe_in),
    .pe_filter      (pe_filter),
    .pe_out         (pe_out),
    .single_count_9 (single_count_9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int exp_sat;
    int exp_trunc;
  } win_vec_t;

  win_vec_t vecs[6];

  function automatic int ref_sat(input int s);
`ifdef PE_SATURATE_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the window model, compare both outputs.
  task automatic step(input logic m, input int a, input int b);
    int s;
    int exp_pulse;
    mode_i    = m;
    pe_in     = 8'(a);
    pe_filter = 8'(b);
    @(posedge clk);
    #1;
    exp_pulse = 0;
    if (rst && m) begin
      win.push_back(a * b);
      if (win.size() == TAPS) begin
        s = 0;
        foreach (win[i]) s += win[i];
        m_out     = ref_sat(s);
        exp_pulse = 1;
        win.delete();
      end
    end
    check("pulse", int'(single_count_9), exp_pulse);
    check("pe_out", int'(pe_out), m_out);
  endtask

  task automatic run_window(input int a, input int b, input int exp_out);
    for (int k = 0; k < TAPS; k++) step(1'b1, a, b);
    check("window_out", int'(pe_out), exp_out);
  endtask

  initial begin
    vecs[0] = '{10, 10, 255, 132};
    vecs[1] = '{5, 5, 225, 225};
    vecs[2] = '{2, 2, 36, 36};
    vecs[3] = '{20, 20, 255, 16};
    vecs[4] = '{255, 255, 255, 9};
    vecs[5] = '{0, 0, 0, 0};

    rst = 1'b0; mode_i = 1'b0; pe_in = '0; pe_filter = '0;
    m_out = 0;

    // Held in reset with toggling inputs: outputs stay cleared
    for (int k = 0; k < 6; k++) step(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    @(negedge clk);
    rst = 1'b1;

    run_window(5, 5, 225);

    // Back-to-back windows straight from the table
    foreach (vecs[i]) begin
`ifdef PE_SATURATE_EN
      run_window(vecs[i].a, vecs[i].b, vecs[i].exp_sat);
`else
      run_window(vecs[i].a, vecs[i].b, vecs[i].exp_trunc);
`endif
    end

    // Pause mid-window with garbage operands
    for (int k = 0; k < 4; k++) step(1'b1, 2, 2);
    for (int k = 0; k < 5; k++) step(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    for (int k = 0; k < 5; k++) step(1'b1, 2, 2);
    check("pause_out", int'(pe_out), 36);

    // Establish nonzero pe_out, then async reset mid-window
    run_window(10, 10, ref_sat(900));
    for (int k = 0; k < 5; k++) step(1'b1, 20, 20);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out", int'(pe_out), 0);
    check("async_rst_pulse", int'(single_count_9), 0);
    win.delete();
    m_out = 0;
    @(negedge clk);
    rst = 1'b1;
    run_window(5, 5, 225);

    // Random traffic against the window model
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pe_mac
